// File: rtl/ram_scan_ctrl_if.sv
// Write-request handshake between a requester and ram_scan_ctrl.
// master = requester, slave = controller.
interface ram_scan_ctrl_if;
  logic       wr_req;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_ack;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack
  );
endinterface

// File: rtl/ram_scan_ctrl.sv
// Owns the 32x4 RAM pins; arbitrates user writes vs a tick-driven scanner.
// Optional write readback check: define RAM_WR_READBACK_EN (adds wr_err).
module ram_scan_ctrl #(
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  ram_scan_ctrl_if.slave  wr,
`ifdef RAM_WR_READBACK_EN
  output logic            wr_err,
`endif
  output logic [4:0]      ram_address,
  output logic [3:0]      ram_data_in,
  output logic            ram_write_enable,
  input  logic [3:0]      ram_data_out,
  output logic [4:0]      disp_addr,
  output logic [3:0]      disp_data,
  output logic            disp_valid
);

`ifdef RAM_WR_READBACK_EN
  typedef enum logic [1:0] {
    SCAN, WRITE, WAIT, VERIFY
  } state_t;
`else
  typedef enum logic [1:0] {
    SCAN, WRITE, WAIT
  } state_t;
`endif

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] scan_ptr;
  logic       tick_pend;

  // Sequencer: one FSM drives every RAM pin, the ack and the display regs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= WAIT;
      cnt              <= 4'(RD_LAT);
      scan_ptr         <= '0;
      tick_pend        <= 1'b0;
      wr.wr_ack        <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_write_enable <= 1'b0;
      disp_addr        <= '0;
      disp_data        <= '0;
      disp_valid       <= 1'b0;
`ifdef RAM_WR_READBACK_EN
      wr_err           <= 1'b0;
`endif
    end else begin
      unique case (state)
        SCAN: begin
          if (wr.wr_req) begin
            ram_address      <= wr.wr_addr;
            ram_data_in      <= wr.wr_data;
            ram_write_enable <= 1'b1;
`ifndef RAM_WR_READBACK_EN
            wr.wr_ack        <= 1'b1;
`endif
            if (tick) tick_pend <= 1'b1;
            state <= WRITE;
          end else if (tick || tick_pend) begin
            scan_ptr    <= scan_ptr + 5'd1;
            ram_address <= scan_ptr + 5'd1;
            tick_pend   <= 1'b0;
            cnt         <= 4'(RD_LAT);
            state       <= WAIT;
          end
        end
        WRITE: begin
          ram_write_enable <= 1'b0;
          if (tick) tick_pend <= 1'b1;
`ifdef RAM_WR_READBACK_EN
          // address/data regs still hold the written word for readback
          cnt   <= 4'(RD_LAT + 1);
          state <= VERIFY;
`else
          wr.wr_ack   <= 1'b0;
          ram_address <= scan_ptr;
          cnt         <= 4'(RD_LAT);
          state       <= WAIT;
`endif
        end
        WAIT: begin
          if (tick) tick_pend <= 1'b1;
          if (cnt == 4'd1) begin
            disp_addr  <= scan_ptr;
            disp_data  <= ram_data_out;
            disp_valid <= 1'b1;
            state      <= SCAN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef RAM_WR_READBACK_EN
        VERIFY: begin
          if (tick) tick_pend <= 1'b1;
          if (cnt == 4'd2) wr.wr_ack <= 1'b1;
          if (cnt == 4'd1) begin
            wr.wr_ack <= 1'b0;
            if (ram_data_out != ram_data_in) wr_err <= 1'b1;
            ram_address <= scan_ptr;
            cnt         <= 4'(RD_LAT);
            state       <= WAIT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        default: state <= SCAN;
      endcase
    end
  end

endmodule
